// File: rtl/arb_pkg.sv
// arb_pkg: shared types and helpers for the round-robin output-FIFO arbiter.
package arb_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, SERVE = 2'd1, BLOCKED = 2'd2} arb_state_t;
   localparam int DATA_SIZE_DEF = 12;
   localparam int NUM_CH_DEF    = 4;
   localparam int NUM_OUT_DEF   = 4;
   localparam int CNT_W_DEF     = 5;
   function automatic int unsigned dest_of(input logic [63:0] word, input int unsigned dsz,
                                           input int unsigned dw);
      return 32'((word >> (dsz - dw)) & ((64'd1 << dw) - 64'd1));
   endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: round-robin one-hot picker (rotate, isolate lowest request, rotate back).
module rr_pick #(
   parameter int NUM_CH = 4
) (
   input  logic [NUM_CH-1:0]         req_i,
   input  logic [$clog2(NUM_CH)-1:0] ptr_i,
   output logic [NUM_CH-1:0]         grant_o,
   output logic                      valid_o
);
   logic [2*NUM_CH-1:0] rot_w, back_w;
   logic [NUM_CH-1:0]   rot, pe;
   always_comb begin
      rot_w   = {req_i, req_i} >> ptr_i;
      rot     = rot_w[NUM_CH-1:0];
      pe      = rot & (~rot + NUM_CH'(1));
      back_w  = {pe, pe} << ptr_i;
      grant_o = back_w[2*NUM_CH-1:NUM_CH];
      valid_o = |req_i;
   end
endmodule

// File: rtl/arbitro_rr_n.sv
// arbitro_rr_n: drains NUM_CH show-ahead FIFOs round-robin into NUM_OUT output FIFOs.
// Define ARB_CNT_EN to build the per-channel forwarded-word counters.
module arbitro_rr_n
   import arb_pkg::*;
#(
   parameter int DATA_SIZE = DATA_SIZE_DEF,
   parameter int NUM_CH    = NUM_CH_DEF,
   parameter int NUM_OUT   = NUM_OUT_DEF,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_CH-1:0]           fifo_empty,
   input  logic [NUM_CH*DATA_SIZE-1:0] data_in,
   input  logic [NUM_OUT-1:0]          fifo_af,
   output logic [NUM_CH-1:0]           pop,
   output logic [NUM_OUT-1:0]          push,
   output logic [DATA_SIZE-1:0]        data_out,
   output logic                        idle,
   output logic [1:0]                  arb_state,
   output logic [NUM_CH*CNT_W-1:0]     cont
);
   localparam int DEST_W = $clog2(NUM_OUT);
   localparam int PW     = $clog2(NUM_CH);
   localparam logic [1:0] S_IDLE    = IDLE;
   localparam logic [1:0] S_SERVE   = SERVE;
   localparam logic [1:0] S_BLOCKED = BLOCKED;

   logic [DEST_W-1:0]    dest [NUM_CH];
   logic [NUM_CH-1:0]    elig, grant;
   logic                 valid;
   logic [PW-1:0]        gidx, ptr_q, ptr_d;
   logic [NUM_OUT-1:0]   push_q, push_d;
   logic [DATA_SIZE-1:0] data_q, data_d;
   logic [1:0]           state_q, state_d;

   // A channel is eligible only if its head word's destination has room.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         dest[i] = DEST_W'(dest_of(64'(data_in[i*DATA_SIZE +: DATA_SIZE]), DATA_SIZE, DEST_W));
         elig[i] = !fifo_empty[i] && !fifo_af[dest[i]];
      end
   end

   rr_pick #(.NUM_CH(NUM_CH)) u_pick (
      .req_i  (elig),
      .ptr_i  (ptr_q),
      .grant_o(grant),
      .valid_o(valid)
   );

   always_comb begin
      gidx = '0;
      for (int i = 0; i < NUM_CH; i++)
         if (grant[i]) gidx = PW'(i);
      push_d  = valid ? NUM_OUT'(1) << dest[gidx] : '0;
      data_d  = valid ? data_in[gidx*DATA_SIZE +: DATA_SIZE] : data_q;
      ptr_d   = !valid ? ptr_q : (gidx == PW'(NUM_CH - 1)) ? '0 : gidx + PW'(1);
      state_d = &fifo_empty ? S_IDLE : valid ? S_SERVE : S_BLOCKED;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         push_q  <= '0;
         data_q  <= '0;
         ptr_q   <= '0;
         state_q <= S_IDLE;
      end else begin
         push_q  <= push_d;
         data_q  <= data_d;
         ptr_q   <= ptr_d;
         state_q <= state_d;
      end
   end

   assign pop       = reset ? '0 : grant;
   assign push      = push_q;
   assign data_out  = data_q;
   assign idle      = &fifo_empty && (push_q == '0);
   assign arb_state = (state_q == 2'd3) ? S_IDLE : state_q;

`ifdef ARB_CNT_EN
   for (genvar i = 0; i < NUM_CH; i++) begin : g_cnt
      logic [CNT_W-1:0] cnt_q;
      always_ff @(posedge clk) begin
         if (reset) cnt_q <= '0;
         else if (grant[i]) cnt_q <= cnt_q + CNT_W'(1);
      end
      assign cont[i*CNT_W +: CNT_W] = cnt_q;
   end
`else
   assign cont = '0;
`endif
endmodule

// File: tb/tb_arbitro_rr_n.sv
// tb_arbitro_rr_n: queue-based FIFO model with a round-robin reference, directed and random traffic.
module tb_arbitro_rr_n;
   localparam int DS = 12, N = 4, NO = 4, CW = 5;

   logic clk = 1'b0;
   logic reset;
   logic [N-1:0]    fifo_empty, pop;
   logic [N*DS-1:0] data_in;
   logic [NO-1:0]   fifo_af, push;
   logic [DS-1:0]   data_out;
   logic            idle;
   logic [1:0]      arb_state;
   logic [N*CW-1:0] cont;

   always #5 clk = ~clk;

   arbitro_rr_n #(.DATA_SIZE(DS), .NUM_CH(N), .NUM_OUT(NO), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .data_in(data_in),
      .fifo_af(fifo_af), .pop(pop), .push(push), .data_out(data_out),
      .idle(idle), .arb_state(arb_state), .cont(cont)
   );

   logic [DS-1:0] q [N][$];
   logic [NO-1:0] af_v;
   int            tests = 0, fails = 0;
   int            ptr, cnt [N];
   logic [NO-1:0] e_push;
   logic [DS-1:0] e_data;
   logic [1:0]    e_state;
   int            order [$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int exp_cnt(input int i);
`ifdef ARB_CNT_EN
      return cnt[i];
`else
      return 0;
`endif
   endfunction

   function automatic int dst(input logic [DS-1:0] w);
      return int'(w >> (DS - 2));
   endfunction

   function automatic int pick();
      for (int k = 0; k < N; k++) begin
         int c = (ptr + k) % N;
         if (q[c].size() > 0 && !af_v[dst(q[c][0])]) return c;
      end
      return -1;
   endfunction

   function automatic bit all_empty();
      for (int i = 0; i < N; i++) if (q[i].size() > 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_reset();
      ptr = 0; e_push = '0; e_data = '0; e_state = 2'd0;
      for (int i = 0; i < N; i++) cnt[i] = 0;
   endtask

   task automatic cycle(input bit rst);
      int g;
      logic [DS-1:0] w;
      @(negedge clk);
      reset   = rst;
      fifo_af = af_v;
      for (int i = 0; i < N; i++) begin
         fifo_empty[i] = (q[i].size() == 0);
         data_in[i*DS +: DS] = (q[i].size() > 0) ? q[i][0] : DS'($urandom);
      end
      #1;
      g = rst ? -1 : pick();
      chk("pop", pop, (g < 0) ? 0 : (64'd1 << g));
      chk("push", push, e_push);
      chk("data_out", data_out, e_data);
      chk("arb_state", arb_state, e_state);
      chk("idle", idle, all_empty() && e_push == '0);
      for (int i = 0; i < N; i++) chk("cont", cont[i*CW +: CW], exp_cnt(i));
      @(posedge clk);
      if (rst) model_reset();
      else begin
         e_state = all_empty() ? 2'd0 : (g >= 0) ? 2'd1 : 2'd2;
         if (g >= 0) begin
            w = q[g].pop_front();
            e_push = NO'(1 << dst(w));
            e_data = w;
            ptr = (g + 1) % N;
            cnt[g] = (cnt[g] + 1) % (1 << CW);
            order.push_back(g);
         end else e_push = '0;
      end
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) cycle(1'b0);
   endtask

   initial begin
      af_v = '0;
      reset = 1'b1;
      fifo_af = '0;
      fifo_empty = '1;
      data_in = '0;
      repeat (2) @(posedge clk);
      model_reset();
      // reset dominates a non-empty input
      q[0].push_back(12'h123);
      cycle(1'b1);
      cycle(1'b1);
      void'(q[0].pop_front());
      cycle(1'b0);

      order.delete();
      q[0].push_back(12'h001); q[1].push_back(12'h501);
      q[2].push_back(12'hA01); q[3].push_back(12'hF01);
      run(6);
      for (int i = 0; i < 4; i++) chk("order_4ch", order[i], i);

      cycle(1'b1);
      order.delete();
      for (int i = 0; i < 3; i++) q[0].push_back(DS'(12'h010 + i));
      for (int i = 0; i < 2; i++) q[1].push_back(DS'(12'h420 + i));
      run(7);
      chk("order_n", order.size(), 5);
      for (int i = 0; i < 5; i++) chk("order_01", order[i], i % 2);
      chk("idle_end", idle, 1);
`ifdef ARB_CNT_EN
      chk("cont0", cont[0 +: CW], 3);
      chk("cont1", cont[CW +: CW], 2);
`else
      chk("cont0", cont[0 +: CW], 0);
      chk("cont1", cont[CW +: CW], 0);
`endif

      order.delete();
      af_v = 4'b0010;
      q[1].push_back(12'h501); q[2].push_back(12'hA01);
      run(2);
      af_v = '0;
      run(2);
      chk("skip_n", order.size(), 2);
      chk("skip_first", order[0], 2);
      chk("skip_second", order[1], 1);

      af_v = 4'b0001;
      for (int i = 0; i < N; i++) q[i].push_back(DS'(12'h030 + i));
      run(3);
      chk("blocked", arb_state, 2);
      chk("blk_pop", pop, 0);
      af_v = '0;
      run(6);

      cycle(1'b1);
      for (int i = 0; i < 33; i++) q[3].push_back(DS'($urandom));
      run(35);
`ifdef ARB_CNT_EN
      chk("cont3_wrap", cont[3*CW +: CW], 1);
`else
      chk("cont3_wrap", cont[3*CW +: CW], 0);
`endif

      for (int k = 0; k < 2000; k++) begin
         for (int i = 0; i < N; i++)
            if (q[i].size() < 8 && $urandom_range(0, 2) != 0) q[i].push_back(DS'($urandom));
         af_v = ($urandom_range(0, 3) == 0) ? NO'($urandom) : '0;
         cycle($urandom_range(0, 99) == 0);
      end
      af_v = '0;
      run(40);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
